// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: run/step/halt sequencer with load-use stall, IF/ID flush, halt drain and perf counters (i_ debug/hazard inputs, o_ stage enables, state, counters)
module pipeline_ctrl #(
  parameter int NB_REG_ADDR = 5,
  parameter int NB_OPCODE = 6,
  parameter int NB_CNT = 32,
  parameter int DRAIN_CYCLES = 4,
  parameter logic [NB_OPCODE-1:0] HALT_OPCODE = 6'b111111
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_run,
  input  logic                   i_step,
  input  logic                   i_halt_req,
  input  logic [NB_OPCODE-1:0]   i_opcode_id,
  input  logic [NB_REG_ADDR-1:0] i_rs_id,
  input  logic [NB_REG_ADDR-1:0] i_rt_id,
  input  logic                   i_uses_rt_id,
  input  logic                   i_mem_read_ex,
  input  logic [NB_REG_ADDR-1:0] i_rt_ex,
  input  logic                   i_branch_taken,
  input  logic                   i_jump,
  output logic                   o_valid,
  output logic                   o_pc_en,
  output logic                   o_if_id_en,
  output logic                   o_if_id_flush,
  output logic                   o_id_ex_bubble,
  output logic                   o_halted,
  output logic [2:0]             o_state,
  output logic [NB_CNT-1:0]      o_cycle_count,
  output logic [NB_CNT-1:0]      o_stall_count
);
  localparam int NB_DRN = (DRAIN_CYCLES > 1) ? $clog2(DRAIN_CYCLES) : 1;
  typedef enum logic [2:0] {IDLE = 3'd0, RUN = 3'd1, STEP = 3'd2, DRAIN = 3'd3, DONE = 3'd4} state_t;
  state_t r_state, w_next;
  logic [NB_DRN-1:0] r_drain;
  logic [NB_CNT-1:0] r_cycle, r_stall;
  logic w_load_use, w_halt_id, w_act, w_drain;
  assign w_load_use = i_mem_read_ex & (i_rt_ex != '0) &
                      ((i_rt_ex == i_rs_id) | (i_uses_rt_id & (i_rt_ex == i_rt_id)));
  assign w_halt_id = (i_opcode_id == HALT_OPCODE) & ~w_load_use;
  assign w_act = (r_state == RUN) | (r_state == STEP);
  assign w_drain = r_state == DRAIN;
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    w_next = i_run ? RUN : i_step ? STEP : IDLE;
      RUN:     w_next = i_halt_req ? IDLE : w_halt_id ? DRAIN : RUN;
      STEP:    w_next = w_halt_id ? DRAIN : IDLE;
      DRAIN:   w_next = (r_drain == '0) ? DONE : DRAIN;
      DONE:    w_next = DONE;
      default: w_next = IDLE;
    endcase
  end
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_state <= IDLE;
      r_drain <= '0;
      r_cycle <= '0;
      r_stall <= '0;
    end else begin
      r_state <= w_next;
      r_drain <= (w_next == DRAIN && !w_drain) ? NB_DRN'(DRAIN_CYCLES - 1) :
                 (w_drain && r_drain != '0) ? r_drain - NB_DRN'(1) : r_drain;
      r_cycle <= o_valid ? r_cycle + NB_CNT'(1) : r_cycle;
      r_stall <= (w_act & w_load_use) ? r_stall + NB_CNT'(1) : r_stall;
    end
  end
  assign o_valid = w_act | w_drain;
  assign o_pc_en = w_act & ~w_load_use;
  assign o_if_id_en = w_act & ~w_load_use;
  assign o_if_id_flush = w_drain | (w_act & ~w_load_use & (i_branch_taken | i_jump));
  assign o_id_ex_bubble = w_drain | (w_act & w_load_use);
  assign o_halted = r_state == DONE;
  assign o_state = r_state;
  assign o_cycle_count = r_cycle;
  assign o_stall_count = r_stall;
endmodule
